// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct encodings, alu_op codes, FSM states and the opcode/funct decoder
package alu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_SLLV = 6'h04, FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07, FN_JR = 6'h08, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV = 6'h1A, FN_DIVU = 6'h1B;
  localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;
  // low nibble carries the classic 4-bit ALU control code; bit 4 marks the extended ops
  typedef enum logic [4:0] {
    ALU_ADD = 5'h00, ALU_SUB = 5'h01, ALU_AND = 5'h02, ALU_OR = 5'h03, ALU_XOR = 5'h04,
    ALU_NOR = 5'h05, ALU_SLL = 5'h06, ALU_SRL = 5'h07, ALU_SRA = 5'h08, ALU_SLT = 5'h09,
    ALU_SLTU = 5'h0A, ALU_JR = 5'h0B, ALU_JAL = 5'h0D, ALU_LUI = 5'h0F,
    ALU_MULT = 5'h10, ALU_MULTU = 5'h11, ALU_DIV = 5'h12, ALU_DIVU = 5'h13,
    ALU_MFHI = 5'h14, ALU_MFLO = 5'h15, ALU_ILL = 5'h16
  } alu_op_e;
  typedef struct packed {
    alu_op_e op;
    logic    var_sh;
  } dec_t;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
  function automatic dec_t decode(input logic [5:0] opcode, input logic [5:0] funct);
    dec_t d;
    d.op = ALU_ILL;
    d.var_sh = opcode == OP_RTYPE && (funct == FN_SLLV || funct == FN_SRLV || funct == FN_SRAV);
    if (opcode == OP_RTYPE)
      case (funct)
        FN_ADD: d.op = ALU_ADD;
        FN_SUB: d.op = ALU_SUB;
        FN_AND: d.op = ALU_AND;
        FN_OR: d.op = ALU_OR;
        FN_XOR: d.op = ALU_XOR;
        FN_NOR: d.op = ALU_NOR;
        FN_SLT: d.op = ALU_SLT;
        FN_SLTU: d.op = ALU_SLTU;
        FN_SLL, FN_SLLV: d.op = ALU_SLL;
        FN_SRL, FN_SRLV: d.op = ALU_SRL;
        FN_SRA, FN_SRAV: d.op = ALU_SRA;
        FN_JR: d.op = ALU_JR;
        FN_MFHI: d.op = ALU_MFHI;
        FN_MFLO: d.op = ALU_MFLO;
        FN_MULT: d.op = ALU_MULT;
        FN_MULTU: d.op = ALU_MULTU;
        FN_DIV: d.op = ALU_DIV;
        FN_DIVU: d.op = ALU_DIVU;
        default: d.op = ALU_ILL;
      endcase
    else
      case (opcode)
        OP_LW, OP_SW, OP_ADDI: d.op = ALU_ADD;
        OP_BEQ, OP_BNE: d.op = ALU_SUB;
        OP_SLTI: d.op = ALU_SLT;
        OP_SLTIU: d.op = ALU_SLTU;
        OP_ANDI: d.op = ALU_AND;
        OP_ORI: d.op = ALU_OR;
        OP_XORI: d.op = ALU_XOR;
        OP_LUI: d.op = ALU_LUI;
        OP_J, OP_JAL: d.op = ALU_JAL;
        default: d.op = ALU_ILL;
      endcase
    return d;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shared radix-2 shift-add multiplier / restoring divider, one bit per cycle
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              start,
  input  logic              sgn,
  input  logic              is_div,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CW = $clog2(DATA_W) + 1;
  logic [CW-1:0] cnt;
  logic [2*DATA_W-1:0] acc, acc_n, prod;
  logic [DATA_W-1:0] mb, a_raw, ma, mbs, r_sub, q, r;
  logic [DATA_W:0] sum, rs;
  logic div_q, neg_q, neg_r, dz, ge;
  always_comb begin
    ma = sgn && a[DATA_W-1] ? -a : a;
    mbs = sgn && b[DATA_W-1] ? -b : b;
    sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, acc[0] ? mb : {DATA_W{1'b0}}};
    rs = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    ge = rs >= {1'b0, mb};
    r_sub = rs[DATA_W-1:0] - mb;
    acc_n = div_q ? {ge ? r_sub : rs[DATA_W-1:0], acc[DATA_W-2:0], ge} : {sum, acc[DATA_W-1:1]};
    prod = neg_q ? -acc_n : acc_n;
    q = acc_n[DATA_W-1:0];
    r = acc_n[2*DATA_W-1:DATA_W];
    hi = !div_q ? prod[2*DATA_W-1:DATA_W] : dz ? a_raw : neg_r ? -r : r;
    lo = !div_q ? prod[DATA_W-1:0] : dz ? {DATA_W{1'b1}} : neg_q ? -q : q;
    done = cnt == CW'(1);
  end
  // the last step's result is presented combinationally so completion lands DATA_W+1 cycles after accept
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      cnt <= '0;
      acc <= '0;
      mb <= '0;
      a_raw <= '0;
      div_q <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else if (start) begin
      cnt <= CW'(DATA_W);
      acc <= {{DATA_W{1'b0}}, is_div ? ma : mbs};
      mb <= is_div ? mbs : ma;
      a_raw <= a;
      div_q <= is_div;
      neg_q <= sgn && (a[DATA_W-1] ^ b[DATA_W-1]);
      neg_r <= sgn && a[DATA_W-1];
      dz <= is_div && b == '0;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
      acc <= acc_n;
    end
endmodule

// File: rtl/alu_muldiv_exec.sv
// alu_muldiv_exec: execute stage with single-cycle ALU, HI/LO and iterative MUL/DIV behind valid/ready
module alu_muldiv_exec
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic [DATA_W-1:0]  i_a,
  input  logic [DATA_W-1:0]  i_b,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_valid,
  output logic [DATA_W-1:0]  o_result,
  output logic               o_zero,
  output logic               o_illegal,
  output logic [DATA_W-1:0]  o_hi,
  output logic [DATA_W-1:0]  o_lo,
  output logic               o_busy
);
  state_e state, state_n;
  dec_t dec;
  logic accept, is_md, is_div, sgn, done;
  logic [SHAMT_W-1:0] sh;
  logic [DATA_W-1:0] res, hi_q, lo_q, it_hi, it_lo;
  assign dec = decode(i_opcode, i_funct);
  assign o_ready = state == ST_IDLE;
  assign o_busy = !o_ready;
  assign accept = i_valid && o_ready;
  assign is_md = dec.op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
  assign is_div = dec.op inside {ALU_DIV, ALU_DIVU};
  assign sgn = dec.op inside {ALU_MULT, ALU_DIV};
  assign sh = dec.var_sh ? i_a[SHAMT_W-1:0] : i_shamt;
  assign o_zero = o_result == '0;
  assign o_hi = hi_q;
  assign o_lo = lo_q;
  always_comb begin
    res = '0;
    case (dec.op)
      ALU_ADD: res = i_a + i_b;
      ALU_SUB: res = i_a - i_b;
      ALU_AND: res = i_a & i_b;
      ALU_OR: res = i_a | i_b;
      ALU_XOR: res = i_a ^ i_b;
      ALU_NOR: res = ~(i_a | i_b);
      ALU_SLT: res = {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: res = {{(DATA_W-1){1'b0}}, i_a < i_b};
      ALU_SLL: res = i_b << sh;
      ALU_SRL: res = i_b >> sh;
      ALU_SRA: res = $signed(i_b) >>> sh;
      ALU_JR: res = i_a;
      ALU_LUI: res = i_b << (DATA_W / 2);
      ALU_MFHI: res = hi_q;
      ALU_MFLO: res = lo_q;
      default: res = '0;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= ST_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (accept && is_md) state_n = is_div ? ST_DIV : ST_MUL;
    else if (state != ST_IDLE && done) state_n = ST_IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_result <= '0;
      o_illegal <= 1'b0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      o_valid <= 1'b0;
      if (accept && !is_md) begin
        o_valid <= 1'b1;
        o_result <= res;
        o_illegal <= dec.op == ALU_ILL;
      end else if (state != ST_IDLE && done) begin
        o_valid <= 1'b1;
        o_result <= it_lo;
        o_illegal <= 1'b0;
        hi_q <= it_hi;
        lo_q <= it_lo;
      end
    end
  alu_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .start(accept && is_md),
    .sgn(sgn),
    .is_div(is_div),
    .a(i_a),
    .b(i_b),
    .done(done),
    .hi(it_hi),
    .lo(it_lo)
  );
endmodule

// File: tb/tb_alu_muldiv_exec.sv
// tb_alu_muldiv_exec: directed vectors against 32-bit and 16-bit instances
module tb_alu_muldiv_exec;
  localparam logic [5:0] R = 6'h00, F_ADD = 6'h20, F_SUB = 6'h22, F_SRA = 6'h03, F_SRAV = 6'h07;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B, F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] O_LUI = 6'h0F, O_BEQ = 6'h04, O_JAL = 6'h03, O_ORI = 6'h0D, O_BAD = 6'h3F;
  logic clk = 1'b0, rst_n = 1'b0, v32 = 1'b0, v16 = 1'b0;
  logic [5:0] opc = '0, fn = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] sh = '0;
  logic rd32, vl32, z32, il32, bz32, rd16, vl16, z16, il16, bz16;
  logic [31:0] res32, hi32, lo32;
  logic [15:0] res16, hi16, lo16;
  int n_cmp = 0, n_err = 0;
  int lat, rlow, pulses;
  always #5 clk = ~clk;
  alu_muldiv_exec #(.DATA_W(32)) u32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(rd32), .i_opcode(opc), .i_funct(fn),
    .i_a(a), .i_b(b), .i_shamt(sh), .o_valid(vl32), .o_result(res32), .o_zero(z32),
    .o_illegal(il32), .o_hi(hi32), .o_lo(lo32), .o_busy(bz32)
  );
  alu_muldiv_exec #(.DATA_W(16)) u16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v16), .o_ready(rd16), .i_opcode(opc), .i_funct(fn),
    .i_a(a[15:0]), .i_b(b[15:0]), .i_shamt(sh[3:0]), .o_valid(vl16), .o_result(res16), .o_zero(z16),
    .o_illegal(il16), .o_hi(hi16), .o_lo(lo16), .o_busy(bz16)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input bit w, input logic [5:0] op, input logic [5:0] f,
                      input logic [31:0] xa, input logic [31:0] xb, input logic [4:0] xs);
    opc = op; fn = f; a = xa; b = xb; sh = xs;
    if (w) v16 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v16 = 1'b0;
  endtask
  task automatic wait_done(input bit w, output int l, output int rl);
    l = 1; rl = 0;
    while (!(w ? vl16 : vl32) && l < 200) begin
      if (!(w ? rd16 : rd32)) rl++;
      @(posedge clk); #1;
      l++;
    end
  endtask
  initial begin
    #12;
    check("rst_valid", vl32, 0); check("rst_result", res32, 0); check("rst_zero", z32, 1);
    check("rst_illegal", il32, 0); check("rst_hi", hi32, 0); check("rst_lo", lo32, 0);
    check("rst_busy", bz32, 0); check("rst_ready", rd32, 1); check("rst16_ready", rd16, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    opc = R; fn = F_ADD; a = 32'h7FFF_FFFF; b = 32'h1; v32 = 1'b1;
    @(posedge clk); #1;
    check("add_valid", vl32, 1); check("add_result", res32, 32'h8000_0000); check("add_zero", z32, 0);
    fn = F_SUB; a = 32'd5; b = 32'd5;
    @(posedge clk); #1; v32 = 1'b0;
    check("sub_valid", vl32, 1); check("sub_result", res32, 0); check("sub_zero", z32, 1);
    send(0, R, F_SRA, 0, 32'h8000_0000, 5'd4); check("sra", res32, 32'hF800_0000);
    send(0, R, F_SRAV, 32'd36, 32'h8000_0000, 5'd0); check("srav", res32, 32'hF800_0000);
    send(0, O_LUI, 0, 0, 32'h1234, 0); check("lui", res32, 32'h1234_0000);
    @(posedge clk); #1;
    check("hold_valid", vl32, 0); check("hold_result", res32, 32'h1234_0000);
    send(0, R, F_SLTU, 32'hFFFF_FFFF, 32'h1, 0); check("sltu", res32, 0);
    send(0, R, F_SLT, 32'hFFFF_FFFF, 32'h1, 0); check("slt", res32, 1);
    send(0, O_JAL, 0, 32'h55, 32'h66, 0);
    check("jal_valid", vl32, 1); check("jal_result", res32, 0); check("jal_illegal", il32, 0);
    send(0, O_BEQ, 0, 32'd5, 32'd5, 0); check("beq_zero", z32, 1);
    send(0, O_ORI, 0, 32'hF0, 32'h0F, 0); check("ori", res32, 32'hFF);
    send(0, O_BAD, 0, 32'd5, 32'd6, 0);
    check("ill_valid", vl32, 1); check("ill_flag", il32, 1); check("ill_result", res32, 0);
    send(0, O_ORI, 0, 32'hF0, 32'h0F, 0); check("ill_clear", il32, 0);
    send(0, R, F_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    opc = R; fn = F_MFHI; v32 = 1'b1;
    wait_done(0, lat, rlow);
    check("mult_latency", lat, 33); check("mult_ready_low", rlow, 32);
    check("mult_result", res32, 32'hFFFF_FFEB); check("mult_hi", hi32, 32'hFFFF_FFFF); check("mult_lo", lo32, 32'hFFFF_FFEB);
    @(posedge clk); #1; v32 = 1'b0;
    check("mfhi_valid", vl32, 1); check("mfhi_result", res32, 32'hFFFF_FFFF);
    send(0, R, F_MFLO, 0, 0, 0); check("mflo", res32, 32'hFFFF_FFEB);
    send(0, R, F_DIV, 32'hFFFF_FFF9, 32'd2, 0); wait_done(0, lat, rlow);
    check("div_latency", lat, 33); check("div_lo", lo32, 32'hFFFF_FFFD); check("div_hi", hi32, 32'hFFFF_FFFF);
    check("div_result", res32, 32'hFFFF_FFFD);
    send(0, R, F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0); wait_done(0, lat, rlow);
    check("divmin_lo", lo32, 32'h8000_0000); check("divmin_hi", hi32, 0);
    send(0, R, F_DIVU, 32'd9, 32'd0, 0); wait_done(0, lat, rlow);
    check("div0_latency", lat, 33); check("div0_lo", lo32, 32'hFFFF_FFFF); check("div0_hi", hi32, 32'd9);
    send(0, R, F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0); wait_done(0, lat, rlow);
    check("multu_hi", hi32, 32'hFFFF_FFFE); check("multu_lo", lo32, 32'h1);
    send(0, R, F_MULT, 32'd3, 32'd5, 0);
    repeat (9) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("abort_ready", rd32, 1); check("abort_busy", bz32, 0);
    check("abort_hi", hi32, 0); check("abort_lo", lo32, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (vl32) pulses++;
    end
    check("abort_no_pulse", pulses, 0); check("abort_hi_after", hi32, 0);
    send(1, R, F_ADD, 32'h7FFF, 32'h1, 0); check("w16_add", res16, 16'h8000);
    send(1, R, F_SRA, 0, 32'h8000, 5'd4); check("w16_sra", res16, 16'hF800);
    send(1, R, F_SRAV, 32'd36, 32'h8000, 0); check("w16_srav", res16, 16'hF800);
    send(1, O_LUI, 0, 0, 32'h12, 0); check("w16_lui", res16, 16'h1200);
    send(1, R, F_MULTU, 32'hFFFF, 32'hFFFF, 0); wait_done(1, lat, rlow);
    check("w16_multu_latency", lat, 17); check("w16_multu_ready_low", rlow, 16);
    check("w16_multu_hi", hi16, 16'hFFFE); check("w16_multu_lo", lo16, 16'h0001);
    send(1, R, F_DIV, 32'hFFF9, 32'd2, 0); wait_done(1, lat, rlow);
    check("w16_div_lo", lo16, 16'hFFFD); check("w16_div_hi", hi16, 16'hFFFF);
    send(1, R, F_DIVU, 32'd9, 32'd0, 0); wait_done(1, lat, rlow);
    check("w16_div0_latency", lat, 17); check("w16_div0_lo", lo16, 16'hFFFF); check("w16_div0_hi", hi16, 16'd9);
    send(1, O_BAD, 0, 32'd1, 32'd2, 0);
    check("w16_ill_valid", vl16, 1); check("w16_ill_flag", il16, 1); check("w16_ill_result", res16, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_exec.md
Name: alu_muldiv_exec

Overview:
- Parametrised execute-stage successor to the combinational ALU-control decoder.
- Decodes opcode/funct, performs the operation, and returns a registered result through a valid/ready handshake.
- Adds HI/LO registers and iterative MULT/MULTU/DIV/DIVU that stall issue while busy.
- Sits between the ID/EX register and EX/MEM; the pipeline stalls on o_ready low.

Parameters:
- DATA_W, 32, operand/result width (even, ≥8)
- SHAMT_W, $clog2(DATA_W), shift-amount width

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_valid  in  1  operation offered
- o_ready  out  1  unit can accept this cycle
- i_opcode  in  6  instruction opcode
- i_funct  in  6  R-type funct
- i_a  in  DATA_W  rs operand
- i_b  in  DATA_W  rt operand or extended immediate
- i_shamt  in  SHAMT_W  shift amount field
- o_valid  out  1  one-cycle completion pulse
- o_result  out  DATA_W  result, held until next completion
- o_zero  out  1  o_result == 0
- o_illegal  out  1  completed op was undecodable
- o_hi, o_lo  out  DATA_W  architectural HI/LO
- o_busy  out  1  multicycle op in progress

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_valid=0, o_result=0, o_zero=1, o_illegal=0, HI=LO=0, o_busy=0, o_ready=1.
- Reset mid-MUL/DIV aborts the operation; no completion pulse is emitted and HI/LO are not written.
- Accept = i_valid & o_ready. o_ready = (state==IDLE).
- Single-cycle ops: result registered, o_valid high the cycle after accept (latency 1). Back-to-back accepts complete every cycle.
- R-type ops:
  - ADD/SUB/AND/OR/XOR/NOR/SLT/SLTU, wrapping arithmetic, no overflow trap.
  - SLL/SRL/SRA shift i_b by i_shamt.
  - SLLV/SRLV/SRAV shift i_b by i_a[SHAMT_W-1:0].
  - JR returns i_a.
  - MFHI (010000) returns HI; MFLO (010010) returns LO.
- I-type ops:
  - LW/SW/ADDI use ADD.
  - BEQ/BNE use SUB; o_zero is the branch condition.
  - SLTI/SLTIU/ANDI/ORI/XORI as named.
  - LUI returns i_b << (DATA_W/2).
- J/JAL return 0 with o_illegal=0.
- Any other encoding completes in 1 cycle with o_result=0, o_illegal=1.
- MULT (011000)/MULTU (011001):
  - Accept → state MUL, o_busy=1, counter=DATA_W.
  - Radix-2 shift-add on magnitudes, one bit per cycle; signed MULT negates the 2*DATA_W product if sign(a)^sign(b).
  - At counter 0: {HI,LO} written, o_valid pulses with o_result=LO, return to IDLE.
  - Total latency DATA_W+1 cycles from accept.
- DIV (011010)/DIVU (011011):
  - Accept → state DIV; restoring division, one quotient bit per cycle, same latency as MUL.
  - LO=quotient, HI=remainder.
  - Signed DIV: quotient sign = sign(a)^sign(b); remainder sign = sign(a), truncation toward zero.
  - Most-negative ÷ -1 gives LO=most-negative, HI=0.
  - Divide by zero gives LO=all ones, HI=i_a, still DATA_W+1 cycles.
- MFHI/MFLO issued during MUL/DIV are blocked by o_ready=0; issued in the cycle after completion, they see the new HI/LO.
- i_valid while o_ready=0: inputs ignored; upstream must hold them.
- o_result/o_illegal hold their last value when o_valid=0.

Decomposition:
- Package alu_pkg:
  - opcode and funct localparams
  - 4-bit alu_op codes (ADD=0000 … SLTU=1010, JR=1011, JAL=1101, LUI=1111) plus MUL/DIV/MFHI/MFLO codes
  - state encoding IDLE/MUL/DIV
  - decode function opcode/funct → alu_op
- Sub-module alu_muldiv_iter: shared iterative multiplier/divider datapath (start, signed, is_div, done, hi, lo). The top holds the FSM, handshake and single-cycle datapath.

Test Plan:
- Reset mid-MULT (assert i_rst_n=0 at cycle 10) → o_valid never pulses, HI=LO=0, o_ready=1 immediately.
- ADD a=0x7FFFFFFF, b=1 then SUB a=5, b=5 on consecutive cycles → o_valid 2 consecutive cycles, results 0x80000000 (o_zero=0) then 0 (o_zero=1).
- SRA b=0x80000000, shamt=4 → 0xF8000000. SRAV a=36 (low 5 bits=4) → same. LUI b=0x1234 → 0x12340000.
- MULT a=-3, b=7 → o_ready low 32 cycles, completion at accept+33, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFHI offered during busy stalls, then returns 0xFFFFFFFF.
- DIV a=-7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9.
- opcode 0x3F → o_valid next cycle, o_illegal=1, o_result=0. Repeat the suite with DATA_W=16: MULTU 0xFFFF*0xFFFF → HI=0xFFFE, LO=0x0001, 17-cycle latency.
